// File: rtl/pulse_rate_calc_pkg.sv
// Shared types and constants for the pulse-rate pipeline.
// Holds the measurement FSM encoding and datapath widths.
package pulse_rate_calc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SUM_W = 9;
  localparam int AVG_W = 11;
  localparam int CMP_W = 12;
  localparam int CNT_W = 12;
  localparam int GAP_W = 8;
  localparam int PK_W  = 8;

  function automatic logic [7:0] sat_scale(
    input logic [PK_W-1:0] pk,
    input int              mult
  );
    logic [15:0] p;
    p = 16'(pk) * 16'(mult);
    return (p > 16'd255) ? 8'hFF : p[7:0];
  endfunction

endpackage

// File: rtl/pulse_rate_calc_peak.sv
// Hysteresis peak detector with a refractory gap.
// Emits a 1-cycle o_peak on each accepted falling edge.
module pulse_peak_detect
  import pulse_rate_calc_pkg::*;
#(
  parameter int HYST    = 8,
  parameter int MIN_GAP = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_eval,
  input  logic [AVG_W-1:0] i_avg,
  output logic             o_peak
);

  logic [AVG_W-1:0] r_ref;
  logic             r_rising;
  logic             r_first;
  logic [GAP_W-1:0] r_gap;

  logic [CMP_W-1:0] w_avg;
  logic [CMP_W-1:0] w_ref;
  logic             w_up;
  logic             w_dn;
  logic             w_gap_ok;

  assign w_avg    = CMP_W'(i_avg);
  assign w_ref    = CMP_W'(r_ref);
  assign w_up     = w_avg >= w_ref + CMP_W'(HYST);
  assign w_dn     = w_avg + CMP_W'(HYST) <= w_ref;
  assign w_gap_ok = r_gap >= GAP_W'(MIN_GAP);
  assign o_peak   = i_eval && !r_first && r_rising
                    && w_dn && w_gap_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ref    <= '0;
      r_rising <= 1'b0;
      r_first  <= 1'b0;
      r_gap    <= '0;
    end else if (i_clr) begin
      r_ref    <= '0;
      r_rising <= 1'b0;
      r_first  <= 1'b1;
      r_gap    <= GAP_W'(MIN_GAP);
    end else if (i_eval) begin
      if (o_peak) begin
        r_gap <= '0;
      end else if (r_gap != '1) begin
        r_gap <= r_gap + 1'b1;
      end
      if (r_first) begin
        r_ref    <= i_avg;
        r_rising <= 1'b0;
        r_first  <= 1'b0;
      end else if (r_rising) begin
        if (w_avg > w_ref) begin
          r_ref <= i_avg;
        end else if (w_dn) begin
          r_rising <= 1'b0;
          r_ref    <= i_avg;
        end
      end else begin
        if (w_up) begin
          r_rising <= 1'b1;
          r_ref    <= i_avg;
        end else if (w_avg < w_ref) begin
          r_ref <= i_avg;
        end
      end
    end
  end

endmodule

// File: rtl/pulse_rate_calc.sv
// Frame-sum to BPM: 4-tap smoothing, peak counting over
// a fixed frame window, then scaling to beats per minute.
module pulse_rate_calc
  import pulse_rate_calc_pkg::*;
#(
  parameter int WINDOW_FRAMES = 600,
  parameter int BPM_MULT      = 6,
  parameter int HYST          = 8,
  parameter int MIN_GAP       = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             sum_stb,
  output logic             busy,
  output logic [7:0]       bpm,
  output logic             bpm_valid,
  output logic             peak_led
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW_FRAMES);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_tap [4];
  logic             r_eval;
  logic [PK_W-1:0]  r_peaks;
  logic             r_led;
  logic [7:0]       r_bpm;
  logic             r_bpm_valid;

  logic             w_start;
  logic             w_take;
  logic             w_peak;
  logic [AVG_W-1:0] w_avg;

  assign w_start = start && (r_state == S_IDLE);
  assign w_take  = sum_stb && ((r_state == S_FILL)
                   || (r_state == S_RUN && r_cnt != WIN));
  assign w_avg   = AVG_W'(r_tap[0]) + AVG_W'(r_tap[1])
                 + AVG_W'(r_tap[2]) + AVG_W'(r_tap[3]);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_FILL;
      S_FILL: if (w_take && r_cnt == CNT_W'(3)) w_next = S_RUN;
      S_RUN:  if (r_cnt == WIN) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tap       <= '{default: '0};
      r_eval      <= 1'b0;
      r_peaks     <= '0;
      r_led       <= 1'b0;
      r_bpm       <= '0;
      r_bpm_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_eval      <= 1'b0;
      r_bpm_valid <= 1'b0;
      if (w_start) begin
        r_cnt   <= '0;
        r_tap   <= '{default: '0};
        r_peaks <= '0;
      end else begin
        if (w_take) begin
          r_tap[0] <= sum_in;
          r_tap[1] <= r_tap[0];
          r_tap[2] <= r_tap[1];
          r_tap[3] <= r_tap[2];
          r_cnt    <= r_cnt + 1'b1;
          r_eval   <= (r_state == S_RUN);
        end
        if (w_peak) begin
          r_led <= ~r_led;
          if (r_peaks != '1) r_peaks <= r_peaks + 1'b1;
        end
        // last peak update lands before DONE reads r_peaks
        if (r_state == S_DONE) begin
          r_bpm       <= sat_scale(r_peaks, BPM_MULT);
          r_bpm_valid <= 1'b1;
        end
      end
    end
  end

  pulse_peak_detect #(
    .HYST    (HYST),
    .MIN_GAP (MIN_GAP)
  ) u_peak (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_start),
    .i_eval (r_eval),
    .i_avg  (w_avg),
    .o_peak (w_peak)
  );

  assign busy      = (r_state != S_IDLE);
  assign bpm       = r_bpm;
  assign bpm_valid = r_bpm_valid;
  assign peak_led  = r_led;

endmodule

// File: tb/tb_pulse_rate_calc.sv
// Bench for pulse_rate_calc: table vectors, random waves
// and hand sequences against a window-level peak model.
module tb_pulse_rate_calc;

  localparam int N    = 600;
  localparam int HYS  = 8;
  localparam int GAP  = 18;
  localparam int MULT = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [8:0] sum_in;
  logic       sum_stb;
  logic       busy;
  logic [7:0] bpm;
  logic       bpm_valid;
  logic       peak_led;

  int errs   = 0;
  int checks = 0;
  int samp [N];
  int vcnt   = 0;
  int tcnt   = 0;
  logic prev_led = 1'b0;

  typedef struct {
    int lo;
    int hi;
    int half;
    int ph;
    int exp_bpm;
  } vec_t;

  vec_t tbl [4];

  always #5 clk = ~clk;

  pulse_rate_calc dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sum_in    (sum_in),
    .sum_stb   (sum_stb),
    .busy      (busy),
    .bpm       (bpm),
    .bpm_valid (bpm_valid),
    .peak_led  (peak_led)
  );

  always @(posedge clk) begin
    #1;
    if (bpm_valid) vcnt++;
    if (peak_led !== prev_led) tcnt++;
    prev_led = peak_led;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_peaks();
    int a, rv, last, pk, e;
    bit rising;
    rv = 0; rising = 0; pk = 0;
    last = -GAP - 1;
    for (int k = 4; k < N; k++) begin
      a = samp[k] + samp[k-1] + samp[k-2] + samp[k-3];
      e = k - 4;
      if (e == 0) begin
        rv = a; rising = 0;
      end else if (!rising) begin
        if (a >= rv + HYS) begin rising = 1; rv = a; end
        else if (a < rv) rv = a;
      end else begin
        if (a > rv) rv = a;
        else if (a + HYS <= rv) begin
          rising = 0; rv = a;
          if (e - last - 1 >= GAP) begin pk++; last = e; end
        end
      end
    end
    return pk;
  endfunction

  function automatic void fill_wave(input int lo, input int hi,
                                    input int half, input int ph,
                                    input int noise);
    int v;
    for (int i = 0; i < N; i++) begin
      v = (((i + ph) / half) % 2 == 1) ? hi : lo;
      if (noise > 0) v += $urandom_range(noise, 0);
      samp[i] = (v > 511) ? 511 : v;
    end
  endfunction

  task automatic measure(input string nm, input bit co_stb,
                         input int mid_start, input int rst_at,
                         input int exp_bpm);
    int v0, t0, pk, mb, got;
    bit seen;
    v0 = vcnt; t0 = tcnt;
    pk = model_peaks();
    mb = (pk * MULT > 255) ? 255 : pk * MULT;
    @(negedge clk);
    start = 1'b1;
    if (co_stb) begin sum_stb = 1'b1; sum_in = 9'd511; end
    @(negedge clk);
    start = 1'b0; sum_stb = 1'b0;
    check({nm, "_busy"}, int'(busy), 1);
    for (int i = 0; i < N; i++) begin
      if (i == rst_at) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check({nm, "_rst_noval"}, vcnt - v0, 0);
        check({nm, "_rst_bpm"}, int'(bpm), 0);
        check({nm, "_rst_busy"}, int'(busy), 0);
        check({nm, "_rst_led"}, int'(peak_led), 0);
        return;
      end
      if (i == N - 1) check({nm, "_no_early"}, vcnt - v0, 0);
      if (i == mid_start) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sum_in = 9'(samp[i]); sum_stb = 1'b1;
      @(negedge clk);
      sum_stb = 1'b0;
      @(negedge clk);
    end
    seen = 0; got = -1;
    for (int c = 0; c < 20; c++) begin
      if (bpm_valid) begin seen = 1; got = int'(bpm); break; end
      @(negedge clk);
    end
    check({nm, "_valid_seen"}, int'(seen), 1);
    if (exp_bpm >= 0) check({nm, "_bpm_tbl"}, got, exp_bpm);
    check({nm, "_bpm_model"}, got, mb);
    repeat (3) @(negedge clk);
    check({nm, "_one_valid"}, vcnt - v0, 1);
    check({nm, "_led_toggles"}, tcnt - t0, pk);
    check({nm, "_bpm_held"}, int'(bpm), mb);
    check({nm, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    tbl[0] = '{lo: 100, hi: 100, half: 30, ph: 0,  exp_bpm: 0};
    tbl[1] = '{lo: 80,  hi: 120, half: 30, ph: 20, exp_bpm: 60};
    tbl[2] = '{lo: 80,  hi: 120, half: 5,  ph: 0,  exp_bpm: 180};
    tbl[3] = '{lo: 99,  hi: 100, half: 5,  ph: 0,  exp_bpm: 0};

    rst = 1'b0; start = 1'b0; sum_stb = 1'b0; sum_in = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sum_stb = ~sum_stb; start = ~start; sum_in = 9'(i * 40);
    end
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_bpm", int'(bpm), 0);
    check("rst_valid", int'(bpm_valid), 0);
    check("rst_led", int'(peak_led), 0);
    start = 1'b0; sum_stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (tbl[t]) begin
      fill_wave(tbl[t].lo, tbl[t].hi, tbl[t].half, tbl[t].ph, 0);
      measure($sformatf("tbl%0d", t), 0, -1, -1, tbl[t].exp_bpm);
    end

    fill_wave(80, 120, 30, 20, 0);
    measure("co_stb", 1, -1, -1, 60);
    measure("mid_start", 0, 100, -1, 60);
    measure("rst_mid", 0, -1, 300, -1);
    measure("after_rst", 0, -1, -1, 60);

    for (int r = 0; r < 3; r++) begin
      int lo;
      lo = $urandom_range(150, 50);
      fill_wave(lo, lo + $urandom_range(60, 0),
                $urandom_range(40, 3), $urandom_range(60, 0),
                $urandom_range(4, 0));
      measure($sformatf("rand%0d", r), 0, -1, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
